// File: rtl/debouncer_pkg.sv
// Shared types for the debouncer slice: the per-cycle decision taken by the
// stability counter.
package debouncer_pkg;

    typedef enum logic [1:0] {
        ACT_CLEAR,
        ACT_HOLD,
        ACT_COUNT,
        ACT_ACCEPT
    } action_t;

endpackage

// File: rtl/debouncer_sync_2ff.sv
// Two-flop synchronizer that brings the raw switch level into the Clock domain.
module sync_2ff (
    input  logic Clock,
    input  logic Reset,
    input  logic D,
    output logic Q
);

    logic s1;

    // First flop may go metastable; only the second is used downstream.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1 <= 1'b0;
            Q  <= 1'b0;
        end else begin
            s1 <= D;
            Q  <= s1;
        end
    end

endmodule

// File: rtl/debouncer.sv
// Switch debouncer: Out follows the synchronized input only after it has
// differed from Out for 2^Width consecutive enabled cycles.
module debouncer
    import debouncer_pkg::*;
#(
    parameter int Width = 20
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    input  logic In,
    output logic Out
);

    logic             s2;
    logic [Width-1:0] cnt;
    action_t          action;

    sync_2ff u_sync (
        .Clock (Clock),
        .Reset (Reset),
        .D     (In),
        .Q     (s2)
    );

    // Any cycle where the input agrees with Out restarts the stability window;
    // the all-ones count is consumed by the accept, so the counter never wraps.
    always_comb begin
        action = ACT_HOLD;
        if (s2 == Out) begin
            action = ACT_CLEAR;
        end else if (Enable) begin
            if (cnt == '1) begin
                action = ACT_ACCEPT;
            end else begin
                action = ACT_COUNT;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt <= '0;
            Out <= 1'b0;
        end else begin
            case (action)
                ACT_CLEAR:  cnt <= '0;
                ACT_COUNT:  cnt <= cnt + 1'b1;
                ACT_ACCEPT: begin
                    cnt <= '0;
                    Out <= s2;
                end
                default:    cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer (Width=3): behavioural model compared every
// cycle, plus directed latency checks with hand-computed edge counts.
module tb_debouncer;

    localparam int W      = 3;
    localparam int ACCEPT = 1 << W;

    logic clock;
    logic Reset;
    logic Enable;
    logic In;
    logic Out;

    int vectors;
    int miscompares;

    // Behavioural model: synchronizer as a two-deep delay, plus a tally of
    // consecutive enabled edges on which the delayed input disagreed with Out.
    logic m_s1;
    logic m_s2;
    logic m_out;
    int   m_run;

    debouncer #(.Width(W)) dut (
        .Clock  (clock),
        .Reset  (Reset),
        .Enable (Enable),
        .In     (In),
        .Out    (Out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        m_s1  = 1'b0;
        m_s2  = 1'b0;
        m_out = 1'b0;
        m_run = 0;
    end

    always @(posedge clock) begin
        if (Reset) begin
            m_s1  = 1'b0;
            m_s2  = 1'b0;
            m_out = 1'b0;
            m_run = 0;
        end else begin
            if (m_s2 == m_out) begin
                m_run = 0;
            end else if (Enable) begin
                m_run = m_run + 1;
                if (m_run == ACCEPT) begin
                    m_out = m_s2;
                    m_run = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = In;
        end
    end

    // Outputs only move on the rising edge, so the falling edge is a safe sample point.
    always @(negedge clock) begin
        check_output("out_vs_model", {31'd0, Out}, {31'd0, m_out});
        check_output("cnt_vs_model", {29'd0, dut.cnt}, m_run);
    end

    // Counts rising edges until Out reaches target; -1 if it never does.
    task automatic measure(input logic target, input bit toggle_en, output int edges);
        edges = -1;
        for (int n = 1; n <= 60; n++) begin
            Enable = toggle_en ? (n % 2 == 1) : 1'b1;
            @(posedge clock);
            #1;
            if (Out === target) begin
                edges = n;
                break;
            end
            @(negedge clock);
        end
        Enable = 1'b1;
    endtask

    task automatic apply_stimulus();
        int  edges;
        int  hold;
        bit  found;
        logic held_out;

        // Reset held with In high: nothing may move.
        Reset  = 1'b1;
        Enable = 1'b1;
        In     = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_output("reset_out", {31'd0, Out}, 32'd0);
            check_output("reset_cnt", {29'd0, dut.cnt}, 32'd0);
        end
        Reset = 1'b0;
        measure(1'b1, 1'b0, edges);
        check_output("release_latency", edges, 32'd10);

        @(negedge clock);
        In = 1'b0;
        measure(1'b0, 1'b0, edges);
        check_output("fall_latency", edges, 32'd10);

        // Bounce: 5 high, 1 low, then steady high.
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            In = 1'b1;
            @(negedge clock);
        end
        In = 1'b0;
        @(negedge clock);
        check_output("bounce_out_low", {31'd0, Out}, 32'd0);
        In = 1'b1;
        measure(1'b1, 1'b0, edges);
        check_output("bounce_latency", edges, 32'd10);

        @(negedge clock);
        In = 1'b0;
        measure(1'b0, 1'b0, edges);
        check_output("fall_latency2", edges, 32'd10);

        // Enable high on odd edges only: 8th enabled mismatch edge is edge 17.
        @(negedge clock);
        In = 1'b1;
        measure(1'b1, 1'b1, edges);
        check_output("gated_latency", edges, 32'd17);

        @(negedge clock);
        In = 1'b0;
        measure(1'b0, 1'b0, edges);
        check_output("fall_latency3", edges, 32'd10);

        // Reset mid-count at cnt==5, then a fresh full window.
        @(negedge clock);
        In    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (dut.cnt == 3'd5) begin
                found = 1'b1;
                break;
            end
        end
        check_output("midcount_reached", {31'd0, found}, 32'd1);
        Reset = 1'b1;
        @(negedge clock);
        check_output("midcount_cnt", {29'd0, dut.cnt}, 32'd0);
        check_output("midcount_out", {31'd0, Out}, 32'd0);
        Reset = 1'b0;
        measure(1'b1, 1'b0, edges);
        check_output("midcount_latency", edges, 32'd10);

        // Enable permanently low: Out is frozen whatever In does.
        @(negedge clock);
        Enable   = 1'b0;
        held_out = Out;
        for (int i = 0; i < 200; i++) begin
            In = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        check_output("disabled_out", {31'd0, Out}, {31'd0, held_out});

        // Random: runs of varying length, mostly-enabled, rare reset.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                In   = ~In;
                hold = $urandom_range(1, 16);
            end
            hold   = hold - 1;
            Enable = ($urandom_range(0, 3) != 0);
            Reset  = ($urandom_range(0, 199) == 0);
            @(negedge clock);
        end
        Reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b1;
        Enable      = 1'b1;
        In          = 1'b1;
        apply_stimulus();
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
